// File: rtl/sram_stream_reader.sv
// sram_stream_reader: issues consecutive SRAM reads from a base address and streams
// the returned words through a 2-entry FIFO as a valid/ready stream.
module sram_stream_reader #(
    parameter int DWIDTH = 24,
    parameter int AWIDTH = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [AWIDTH-1:0] base_addr,
    input  logic [AWIDTH:0]   len,
    output logic              busy,
    output logic              done,
    output logic [AWIDTH-1:0] sram_addr_r,
    input  logic [DWIDTH-1:0] sram_data_i,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DWIDTH-1:0] m_data,
    output logic              m_last
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t            state_q, state_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [AWIDTH:0]   issue_left_q, issue_left_d, out_left_q, out_left_d;
    logic              pend_q, done_q, done_d;
    logic [1:0]        fifo_cnt_q, fifo_cnt_d;
    logic [DWIDTH-1:0] e0_q, e0_d, e1_q, e1_d;
    logic              issue, pop, push;

    assign pop  = m_valid & m_ready;
    assign push = pend_q;
    // Words already held plus the one in flight, minus the one leaving, must leave room.
    assign issue = (state_q == RUN) && (issue_left_q != '0) &&
                   (({1'b0, fifo_cnt_q} + {2'b0, pend_q} - {2'b0, pop}) <= 3'd1);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        issue_left_d = issue_left_q;
        out_left_d   = pop ? out_left_q - 1'b1 : out_left_q;
        done_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && len == '0) begin
                    done_d = 1'b1;
                end else if (start) begin
                    state_d      = RUN;
                    addr_d       = base_addr;
                    issue_left_d = len;
                    out_left_d   = len;
                end
            end
            RUN: begin
                if (issue) begin
                    addr_d       = addr_q + 1'b1;
                    issue_left_d = issue_left_q - 1'b1;
                    state_d      = (issue_left_q == (AWIDTH+1)'(1)) ? DRAIN : RUN;
                end
            end
            DRAIN: begin
                if (pop && m_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // e0 is the head; it only moves on a pop or on a push into an empty FIFO.
    always_comb begin
        fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, pop};
        e0_d = pop ? ((fifo_cnt_q == 2'd2) ? e1_q : sram_data_i)
                   : ((push && fifo_cnt_q == 2'd0) ? sram_data_i : e0_q);
        e1_d = (push && (pop ? fifo_cnt_q == 2'd2 : fifo_cnt_q == 2'd1)) ? sram_data_i : e1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            issue_left_q <= '0;
            out_left_q   <= '0;
            pend_q       <= 1'b0;
            done_q       <= 1'b0;
            fifo_cnt_q   <= 2'd0;
            e0_q         <= '0;
            e1_q         <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            issue_left_q <= issue_left_d;
            out_left_q   <= out_left_d;
            pend_q       <= issue;
            done_q       <= done_d;
            fifo_cnt_q   <= fifo_cnt_d;
            e0_q         <= e0_d;
            e1_q         <= e1_d;
        end
    end

    assign busy        = state_q != IDLE;
    assign done        = done_q;
    assign sram_addr_r = addr_q;
    assign m_valid     = fifo_cnt_q != 2'd0;
    assign m_data      = e0_q;
    assign m_last      = m_valid && (out_left_q == (AWIDTH+1)'(1));

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && fifo_cnt_q == 2'd2));
endmodule

// File: tb/tb_sram_stream_reader.sv
// tb_sram_stream_reader: drives directed and random transfers against a behavioural
// SRAM and an expected-word queue built from base/len arithmetic.
module tb_sram_stream_reader;
    localparam int DW = 24;
    localparam int AW = 6;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   len = '0;
    logic          busy, done, m_valid, m_last;
    logic          m_ready = 1'b0;
    logic [AW-1:0] sram_addr_r;
    logic [DW-1:0] sram_data, m_data;
    logic [DW-1:0] ram [DEPTH];
    int checks = 0;
    int errors = 0;

    sram_stream_reader #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .sram_addr_r(sram_addr_r), .sram_data_i(sram_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) sram_data <= ram[sram_addr_r];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // rmode: 0 ready always, 1 fixed stall pattern, 2 random ready.
    // restart_at / rst_at: cycle of a spurious start pulse / async reset (-1 = none).
    task automatic xfer(input int base, input int ln, input int rmode,
                        input int restart_at, input int rst_at);
        logic [DW-1:0] q[$];
        logic [DW-1:0] prev_data, w;
        logic          prev_last, prev_stall;
        bit            pat [8] = '{1, 0, 0, 1, 0, 1, 1, 0};
        int            cyc, last_cyc;
        bit            finished;
        for (int i = 0; i < ln; i++) q.push_back(ram[(base + i) % DEPTH]);
        @(negedge clk);
        start = 1'b1; base_addr = AW'(base); len = (AW+1)'(ln);
        cyc = 0; last_cyc = -1; prev_stall = 0; prev_data = '0; prev_last = 0; finished = 0;
        while (cyc < 600 && !finished) begin
            @(negedge clk);
            cyc++;
            start = (cyc == restart_at);
            if (cyc == restart_at) begin
                base_addr = AW'(9);
                len = (AW+1)'(5);
            end
            if (cyc == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_valid", m_valid, 0);
                chk("rst_busy", busy, 0);
                @(negedge clk);
                rst_n = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    chk("rst_no_done", done, 0);
                    chk("rst_idle_valid", m_valid, 0);
                end
                return;
            end
            m_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? pat[cyc % 8] : 1'($urandom);
            if (prev_stall) begin
                chk("stall_data", m_data, prev_data);
                chk("stall_last", m_last, prev_last);
            end
            chk("fifo_cnt_le2", 32'(dut.fifo_cnt_q <= 2'd2), 1);
            chk("busy", busy, (ln != 0 && last_cyc < 0));
            chk("done", done, (cyc == ((ln == 0) ? 1 : last_cyc + 1)));
            if (!m_valid) chk("last_idle", m_last, 0);
            if (m_valid && m_ready) begin
                chk("word_expected", 32'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    w = q.pop_front();
                    chk("m_data", m_data, w);
                    chk("m_last", m_last, (q.size() == 0));
                    if (q.size() == 0) begin
                        last_cyc = cyc;
                        if (rmode == 0) chk("last_cycle", cyc, ln + 2);
                    end
                end
            end else if (m_valid) begin
                chk("m_last_stall", m_last, (q.size() == 1));
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            finished = (ln == 0) ? (cyc == 3) : (last_cyc >= 0 && cyc == last_cyc + 2);
        end
        chk("xfer_finished", finished, 1);
        chk("all_words_out", q.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = DW'(i + 'h100);
        #12;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_valid", m_valid, 0);
        chk("reset_last", m_last, 0);
        chk("reset_addr", sram_addr_r, 0);
        @(negedge clk);
        rst_n = 1'b1;
        xfer(0, 4, 0, -1, -1);
        for (int i = 0; i < DEPTH; i++) ram[i] = DW'($urandom);
        xfer(62, 4, 0, -1, -1);
        xfer(17, 8, 1, -1, -1);
        xfer(3, 0, 0, -1, -1);
        xfer(5, 64, 0, -1, -1);
        xfer(40, 8, 0, 3, -1);
        xfer(20, 8, 0, -1, 4);
        xfer(33, 6, 0, -1, -1);
        for (int t = 0; t < 12; t++)
            xfer(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH)), 2, -1, -1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
